reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station.sv | 216 +++++++++++++++++++++
 tb/tb_reservation_station.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Reservation station: dual-slot issue, two-port CDB wakeup, one registered dispatch port.
// Define RS_AGE_ORDER_EN to select the oldest ready entry instead of the lowest-index one.
module reservation_station #(
  parameter int XLEN  = 32,
  parameter int SIZE  = 8,
  parameter int TAG_W = 6,
  parameter int OP_W  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [1:0]               iss_valid,
  input  logic [1:0][OP_W-1:0]     iss_op,
  input  logic [1:0][TAG_W-1:0]    iss_rd_tag,
  input  logic [1:0][TAG_W-1:0]    iss_src1_tag,
  input  logic [1:0][TAG_W-1:0]    iss_src2_tag,
  input  logic [1:0][XLEN-1:0]     iss_src1_val,
  input  logic [1:0][XLEN-1:0]     iss_src2_val,
  input  logic [1:0]               iss_src1_rdy,
  input  logic [1:0]               iss_src2_rdy,
  input  logic [1:0][XLEN-1:0]     iss_imm,
  input  logic [1:0][XLEN-1:0]     iss_addr,
  input  logic [1:0]               cdb_valid,
  input  logic [1:0][TAG_W-1:0]    cdb_tag,
  input  logic [1:0][XLEN-1:0]     cdb_result,
  output logic                     disp_valid,
  input  logic                     disp_ready,
  output logic [OP_W-1:0]          disp_op,
  output logic [TAG_W-1:0]         disp_rd_tag,
  output logic [XLEN-1:0]          disp_src1,
  output logic [XLEN-1:0]          disp_src2,
  output logic [XLEN-1:0]          disp_imm,
  output logic [XLEN-1:0]          disp_addr,
  output logic                     full,
  output logic [$clog2(SIZE+1)-1:0] count
);
  localparam int IDX_W = $clog2(SIZE);
  localparam int CNT_W = $clog2(SIZE+1);

  logic [SIZE-1:0]  ent_valid, ent_r1, ent_r2, eligible;
  logic [OP_W-1:0]  ent_op   [SIZE];
  logic [TAG_W-1:0] ent_rd   [SIZE];
  logic [TAG_W-1:0] ent_t1   [SIZE];
  logic [TAG_W-1:0] ent_t2   [SIZE];
  logic [XLEN-1:0]  ent_v1   [SIZE];
  logic [XLEN-1:0]  ent_v2   [SIZE];
  logic [XLEN-1:0]  ent_imm  [SIZE];
  logic [XLEN-1:0]  ent_addr [SIZE];

  // {rdy, value} after this cycle's CDB snoop
  logic [XLEN:0]    wk1 [SIZE];
  logic [XLEN:0]    wk2 [SIZE];
  logic [XLEN:0]    iw1 [2];
  logic [XLEN:0]    iw2 [2];

  logic [CNT_W-1:0] cnt;
  logic [1:0]       seen;
  logic [IDX_W-1:0] free0, free1;
  logic [IDX_W-1:0] alloc_idx [2];
  logic [1:0]       alloc;
  logic             sel_found, disp_load, do_disp;
  logic [IDX_W-1:0] sel_idx;

  function automatic logic [XLEN:0] wake(input logic [TAG_W-1:0] tag, input logic rdy,
                                         input logic [XLEN-1:0] val);
    if (rdy) return {1'b1, val};
    if (cdb_valid[0] && cdb_tag[0] == tag) return {1'b1, cdb_result[0]};
    if (cdb_valid[1] && cdb_tag[1] == tag) return {1'b1, cdb_result[1]};
    return {1'b0, val};
  endfunction

  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      wk1[i] = wake(ent_t1[i], ent_r1[i], ent_v1[i]);
      wk2[i] = wake(ent_t2[i], ent_r2[i], ent_v2[i]);
    end
    for (int s = 0; s < 2; s++) begin
      iw1[s] = wake(iss_src1_tag[s], iss_src1_rdy[s], iss_src1_val[s]);
      iw2[s] = wake(iss_src2_tag[s], iss_src2_rdy[s], iss_src2_val[s]);
    end
  end

  always_comb begin
    cnt   = '0;
    seen  = '0;
    free0 = '0;
    free1 = '0;
    for (int i = 0; i < SIZE; i++) begin
      cnt = cnt + CNT_W'(ent_valid[i]);
      if (!ent_valid[i]) begin
        if (seen == 2'd0) free0 = IDX_W'(i);
        else if (seen == 2'd1) free1 = IDX_W'(i);
        if (seen != 2'd2) seen = seen + 2'd1;
      end
    end
  end

  assign count        = cnt;
  assign full         = (cnt > CNT_W'(SIZE - 2));
  assign alloc        = full ? 2'b00 : iss_valid;
  assign alloc_idx[0] = free0;
  assign alloc_idx[1] = iss_valid[0] ? free1 : free0;

`ifdef RS_AGE_ORDER_EN
  logic [IDX_W-1:0] ent_rank [SIZE];
  logic [IDX_W-1:0] sel_rank;
  logic [CNT_W-1:0] base_rank;
`endif

  always_comb begin
    eligible  = ent_valid & ent_r1 & ent_r2;
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef RS_AGE_ORDER_EN
    sel_rank  = '0;
    for (int i = 0; i < SIZE; i++)
      if (eligible[i] && (!sel_found || ent_rank[i] < sel_rank)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_rank  = ent_rank[i];
      end
`else
    for (int i = 0; i < SIZE; i++)
      if (eligible[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
`endif
  end

  assign disp_load = !disp_valid || disp_ready;
  assign do_disp   = disp_load && sel_found && !flush;

  // Free slots come from this cycle's valid bits, so a dispatched entry is reusable only next cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ent_valid <= '0;
      ent_r1    <= '0;
      ent_r2    <= '0;
    end else if (flush) begin
      ent_valid <= '0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        ent_r1[i] <= wk1[i][XLEN];
        ent_r2[i] <= wk2[i][XLEN];
      end
      if (do_disp) ent_valid[sel_idx] <= 1'b0;
      for (int s = 0; s < 2; s++)
        if (alloc[s]) begin
          ent_valid[alloc_idx[s]] <= 1'b1;
          ent_r1[alloc_idx[s]]    <= iw1[s][XLEN];
          ent_r2[alloc_idx[s]]    <= iw2[s][XLEN];
        end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < SIZE; i++) begin
      ent_v1[i] <= wk1[i][XLEN-1:0];
      ent_v2[i] <= wk2[i][XLEN-1:0];
    end
    for (int s = 0; s < 2; s++)
      if (alloc[s]) begin
        ent_op[alloc_idx[s]]   <= iss_op[s];
        ent_rd[alloc_idx[s]]   <= iss_rd_tag[s];
        ent_t1[alloc_idx[s]]   <= iss_src1_tag[s];
        ent_t2[alloc_idx[s]]   <= iss_src2_tag[s];
        ent_v1[alloc_idx[s]]   <= iw1[s][XLEN-1:0];
        ent_v2[alloc_idx[s]]   <= iw2[s][XLEN-1:0];
        ent_imm[alloc_idx[s]]  <= iss_imm[s];
        ent_addr[alloc_idx[s]] <= iss_addr[s];
      end
  end

`ifdef RS_AGE_ORDER_EN
  // New entries take the post-removal count so ranks stay dense
  assign base_rank = cnt - CNT_W'(do_disp);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SIZE; i++) ent_rank[i] <= '0;
    end else if (!flush) begin
      if (do_disp)
        for (int i = 0; i < SIZE; i++)
          if (ent_valid[i] && ent_rank[i] > sel_rank) ent_rank[i] <= ent_rank[i] - IDX_W'(1);
      if (alloc[0]) ent_rank[alloc_idx[0]] <= IDX_W'(base_rank);
      if (alloc[1]) ent_rank[alloc_idx[1]] <= IDX_W'(base_rank + CNT_W'(alloc[0]));
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_valid  <= 1'b0;
      disp_op     <= '0;
      disp_rd_tag <= '0;
      disp_src1   <= '0;
      disp_src2   <= '0;
      disp_imm    <= '0;
      disp_addr   <= '0;
    end else if (flush) begin
      disp_valid <= 1'b0;
    end else if (disp_load) begin
      disp_valid <= sel_found;
      if (sel_found) begin
        disp_op     <= ent_op[sel_idx];
        disp_rd_tag <= ent_rd[sel_idx];
        disp_src1   <= ent_v1[sel_idx];
        disp_src2   <= ent_v2[sel_idx];
        disp_imm    <= ent_imm[sel_idx];
        disp_addr   <= ent_addr[sel_idx];
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed and random checks of reservation_station against an issue-order reference model.
module tb_reservation_station;
  localparam int XLEN = 32, SIZE = 8, TAG_W = 6, OP_W = 8;
  localparam int CNT_W = $clog2(SIZE+1);

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic [1:0]            iss_valid = '0;
  logic [1:0][OP_W-1:0]  iss_op = '0;
  logic [1:0][TAG_W-1:0] iss_rd_tag = '0, iss_src1_tag = '0, iss_src2_tag = '0;
  logic [1:0][XLEN-1:0]  iss_src1_val = '0, iss_src2_val = '0, iss_imm = '0, iss_addr = '0;
  logic [1:0]            iss_src1_rdy = '0, iss_src2_rdy = '0;
  logic [1:0]            cdb_valid = '0;
  logic [1:0][TAG_W-1:0] cdb_tag = '0;
  logic [1:0][XLEN-1:0]  cdb_result = '0;
  logic                  disp_ready = 1'b0;
  logic                  disp_valid, full;
  logic [OP_W-1:0]       disp_op;
  logic [TAG_W-1:0]      disp_rd_tag;
  logic [XLEN-1:0]       disp_src1, disp_src2, disp_imm, disp_addr;
  logic [CNT_W-1:0]      count;

  int n_tests = 0;
  int n_fail  = 0;

  reservation_station #(.XLEN(XLEN), .SIZE(SIZE), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .iss_valid(iss_valid), .iss_op(iss_op), .iss_rd_tag(iss_rd_tag),
    .iss_src1_tag(iss_src1_tag), .iss_src2_tag(iss_src2_tag),
    .iss_src1_val(iss_src1_val), .iss_src2_val(iss_src2_val),
    .iss_src1_rdy(iss_src1_rdy), .iss_src2_rdy(iss_src2_rdy),
    .iss_imm(iss_imm), .iss_addr(iss_addr),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_rd_tag(disp_rd_tag), .disp_src1(disp_src1),
    .disp_src2(disp_src2), .disp_imm(disp_imm), .disp_addr(disp_addr),
    .full(full), .count(count)
  );

  always #5 clock = ~clock;

  // Reference model: entries tagged with an issue sequence number instead of a rank
  logic             m_valid [SIZE];
  logic             m_r1 [SIZE], m_r2 [SIZE];
  logic [OP_W-1:0]  m_op [SIZE];
  logic [TAG_W-1:0] m_rd [SIZE], m_t1 [SIZE], m_t2 [SIZE];
  logic [XLEN-1:0]  m_v1 [SIZE], m_v2 [SIZE], m_imm [SIZE], m_addr [SIZE];
  int               m_seq [SIZE];
  int               seq_ctr = 0;
  logic             m_dv;
  logic [OP_W-1:0]  m_dop;
  logic [TAG_W-1:0] m_drd;
  logic [XLEN-1:0]  m_ds1, m_ds2, m_dimm, m_daddr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < SIZE; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  function automatic logic [XLEN:0] m_wake(input logic [TAG_W-1:0] t, input logic r,
                                           input logic [XLEN-1:0] v);
    if (r) return {1'b1, v};
    for (int p = 0; p < 2; p++)
      if (cdb_valid[p] && cdb_tag[p] == t) return {1'b1, cdb_result[p]};
    return {1'b0, v};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < SIZE; i++) begin
      m_valid[i] = 1'b0; m_r1[i] = 1'b0; m_r2[i] = 1'b0;
    end
    m_dv = 1'b0; m_dop = '0; m_drd = '0;
    m_ds1 = '0; m_ds2 = '0; m_dimm = '0; m_daddr = '0;
  endtask

  task automatic m_put(input int s, input int idx);
    logic [XLEN:0] w1, w2;
    w1 = m_wake(iss_src1_tag[s], iss_src1_rdy[s], iss_src1_val[s]);
    w2 = m_wake(iss_src2_tag[s], iss_src2_rdy[s], iss_src2_val[s]);
    m_valid[idx] = 1'b1;
    m_op[idx] = iss_op[s]; m_rd[idx] = iss_rd_tag[s];
    m_t1[idx] = iss_src1_tag[s]; m_t2[idx] = iss_src2_tag[s];
    {m_r1[idx], m_v1[idx]} = w1;
    {m_r2[idx], m_v2[idx]} = w2;
    m_imm[idx] = iss_imm[s]; m_addr[idx] = iss_addr[s];
    m_seq[idx] = seq_ctr++;
  endtask

  // Advance the model across one rising edge using the inputs now applied
  task automatic m_step();
    int n, f0, f1, sel;
    if (flush) begin
      for (int i = 0; i < SIZE; i++) m_valid[i] = 1'b0;
      m_dv = 1'b0;
      return;
    end
    n = m_count();
    f0 = -1; f1 = -1;
    for (int i = 0; i < SIZE; i++)
      if (!m_valid[i]) begin
        if (f0 < 0) f0 = i;
        else if (f1 < 0) f1 = i;
      end
    sel = -1;
    if (!m_dv || disp_ready) begin
      for (int i = 0; i < SIZE; i++)
        if (m_valid[i] && m_r1[i] && m_r2[i]) begin
`ifdef RS_AGE_ORDER_EN
          if (sel < 0 || m_seq[i] < m_seq[sel]) sel = i;
`else
          if (sel < 0) sel = i;
`endif
        end
      m_dv = (sel >= 0);
      if (sel >= 0) begin
        m_dop = m_op[sel]; m_drd = m_rd[sel]; m_ds1 = m_v1[sel]; m_ds2 = m_v2[sel];
        m_dimm = m_imm[sel]; m_daddr = m_addr[sel];
        m_valid[sel] = 1'b0;
      end
    end
    for (int i = 0; i < SIZE; i++)
      if (m_valid[i]) begin
        {m_r1[i], m_v1[i]} = m_wake(m_t1[i], m_r1[i], m_v1[i]);
        {m_r2[i], m_v2[i]} = m_wake(m_t2[i], m_r2[i], m_v2[i]);
      end
    if (n <= SIZE - 2) begin
      if (iss_valid[0]) m_put(0, f0);
      if (iss_valid[1]) m_put(1, iss_valid[0] ? f1 : f0);
    end
  endtask

  task automatic compare_all();
    chk("count", 64'(count), 64'(m_count()));
    chk("full", 64'(full), 64'(m_count() > SIZE - 2));
    chk("disp_valid", 64'(disp_valid), 64'(m_dv));
    if (m_dv) begin
      chk("disp_op", 64'(disp_op), 64'(m_dop));
      chk("disp_rd_tag", 64'(disp_rd_tag), 64'(m_drd));
      chk("disp_src1", 64'(disp_src1), 64'(m_ds1));
      chk("disp_src2", 64'(disp_src2), 64'(m_ds2));
      chk("disp_imm", 64'(disp_imm), 64'(m_dimm));
      chk("disp_addr", 64'(disp_addr), 64'(m_daddr));
    end
  endtask

  task automatic tick();
    m_step();
    @(posedge clock);
    @(negedge clock);
    iss_valid = '0; cdb_valid = '0; flush = 1'b0;
    compare_all();
  endtask

  task automatic issue(input int s, input logic [OP_W-1:0] op, input logic [TAG_W-1:0] t1,
                       input logic r1);
    iss_valid[s] = 1'b1;
    iss_op[s] = op;
    iss_rd_tag[s] = TAG_W'(op);
    iss_src1_tag[s] = t1; iss_src1_rdy[s] = r1;
    iss_src1_val[s] = r1 ? (32'h1000_0000 | XLEN'(op)) : '0;
    iss_src2_tag[s] = '0; iss_src2_rdy[s] = 1'b1;
    iss_src2_val[s] = 32'h2000_0000 | XLEN'(op);
    iss_imm[s] = 32'h3000_0000 | XLEN'(op);
    iss_addr[s] = 32'h4000_0000 | (XLEN'(op) << 2);
  endtask

  task automatic bcast(input int p, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] r);
    cdb_valid[p] = 1'b1; cdb_tag[p] = t; cdb_result[p] = r;
  endtask

  logic [OP_W-1:0] exp_order [4];

  initial begin
`ifdef RS_AGE_ORDER_EN
    exp_order = '{8'h21, 8'h22, 8'h23, 8'h30};
`else
    exp_order = '{8'h30, 8'h21, 8'h22, 8'h23};
`endif
    m_reset();
    @(negedge clock); @(negedge clock);
    chk("rst_count", 64'(count), 0);
    chk("rst_full", 64'(full), 0);
    chk("rst_disp_valid", 64'(disp_valid), 0);
    chk("rst_disp_op", 64'(disp_op), 0);
    chk("rst_disp_src1", 64'(disp_src1), 0);
    reset = 1'b0;

    // Two ready instructions issued together, first cycle out of reset
    disp_ready = 1'b1;
    issue(0, 8'h01, 0, 1'b1); issue(1, 8'h02, 0, 1'b1);
    tick(); chk("dual_cnt", 64'(count), 2); chk("dual_dv0", 64'(disp_valid), 0);
    tick(); chk("dual_op0", 64'(disp_op), 8'h01); chk("dual_dv1", 64'(disp_valid), 1);
    tick(); chk("dual_op1", 64'(disp_op), 8'h02); chk("dual_cnt0", 64'(count), 0);
    tick(); chk("dual_idle", 64'(disp_valid), 0);

    // Wakeup through CDB port 1 two cycles after issue
    issue(0, 8'h05, 6'd5, 1'b0);
    tick(); tick();
    bcast(1, 6'd5, 32'hDEAD_BEEF);
    tick(); chk("wake_dv0", 64'(disp_valid), 0);
    tick(); chk("wake_dv", 64'(disp_valid), 1); chk("wake_src1", 64'(disp_src1), 32'hDEAD_BEEF);
    tick();

    // Same-cycle broadcast captured at issue
    bcast(0, 6'd9, 32'h0000_1234);
    issue(0, 8'h09, 6'd9, 1'b0);
    tick(); tick();
    chk("same_dv", 64'(disp_valid), 1); chk("same_src1", 64'(disp_src1), 32'h1234);
    tick();

    // Both ports match: port 0 wins
    issue(0, 8'h07, 6'd7, 1'b0);
    tick();
    bcast(0, 6'd7, 32'hAAAA_0000); bcast(1, 6'd7, 32'hBBBB_0000);
    tick(); tick();
    chk("prio_src1", 64'(disp_src1), 32'hAAAA_0000);
    tick();

    // Fill with a stalled consumer
    disp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      issue(0, OP_W'(8'h10 + 2*k), 0, 1'b1); issue(1, OP_W'(8'h11 + 2*k), 0, 1'b1);
      tick();
    end
    chk("fill_cnt", 64'(count), 7); chk("fill_full", 64'(full), 1);
    chk("fill_op", 64'(disp_op), 8'h10);
    for (int k = 0; k < 3; k++) begin
      issue(0, 8'h18, 0, 1'b1); issue(1, 8'h19, 0, 1'b1);
      tick();
      chk("full_cnt", 64'(count), 7); chk("stall_op", 64'(disp_op), 8'h10);
      chk("stall_dv", 64'(disp_valid), 1);
    end
    disp_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("drain_cnt", 64'(count), 0); chk("drain_dv", 64'(disp_valid), 0);

    // Flush with four entries and a held dispatch
    disp_ready = 1'b0;
    issue(0, 8'h50, 0, 1'b1); issue(1, 8'h51, 0, 1'b1); tick();
    issue(0, 8'h52, 0, 1'b1); issue(1, 8'h53, 0, 1'b1); tick();
    issue(0, 8'h54, 0, 1'b1); tick();
    chk("pre_flush_cnt", 64'(count), 4); chk("pre_flush_dv", 64'(disp_valid), 1);
    flush = 1'b1; tick();
    chk("flush_cnt", 64'(count), 0); chk("flush_dv", 64'(disp_valid), 0);

    // Asynchronous reset while a dispatch is held
    issue(0, 8'h60, 0, 1'b1); tick(); tick();
    chk("pre_rst_dv", 64'(disp_valid), 1);
    reset = 1'b1;
    #1;
    chk("arst_dv", 64'(disp_valid), 0); chk("arst_cnt", 64'(count), 0);
    chk("arst_full", 64'(full), 0); chk("arst_op", 64'(disp_op), 0);
    chk("arst_addr", 64'(disp_addr), 0);
    m_reset();
    @(posedge clock); @(negedge clock);
    reset = 1'b0;

    // Selection order after an entry is recycled into index 0
    issue(0, 8'h20, 0, 1'b1); issue(1, 8'h21, 6'd20, 1'b0); tick();
    issue(0, 8'h22, 6'd21, 1'b0); issue(1, 8'h23, 6'd22, 1'b0); tick();
    issue(0, 8'h30, 6'd23, 1'b0); tick();
    chk("age_cnt", 64'(count), 4); chk("age_hold", 64'(disp_op), 8'h20);
    bcast(0, 6'd20, 32'h0000_0A20); bcast(1, 6'd21, 32'h0000_0A21); tick();
    bcast(0, 6'd22, 32'h0000_0A22); bcast(1, 6'd23, 32'h0000_0A23); tick();
    disp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("age_order", 64'(disp_op), 64'(exp_order[k]));
    end
    tick(); chk("age_empty", 64'(count), 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      disp_ready = ($urandom_range(0, 9) < 7);
      for (int s = 0; s < 2; s++)
        if ($urandom_range(0, 2) != 0) begin
          iss_valid[s] = 1'b1;
          iss_op[s] = OP_W'($urandom);
          iss_rd_tag[s] = TAG_W'($urandom);
          iss_src1_tag[s] = TAG_W'($urandom_range(0, 15));
          iss_src2_tag[s] = TAG_W'($urandom_range(0, 15));
          iss_src1_rdy[s] = ($urandom_range(0, 4) < 2);
          iss_src2_rdy[s] = ($urandom_range(0, 4) < 3);
          iss_src1_val[s] = XLEN'($urandom);
          iss_src2_val[s] = XLEN'($urandom);
          iss_imm[s] = XLEN'($urandom);
          iss_addr[s] = XLEN'($urandom);
        end
      for (int p = 0; p < 2; p++)
        if ($urandom_range(0, 1) == 1)
          bcast(p, TAG_W'($urandom_range(0, 15)), XLEN'($urandom));
      flush = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
